// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux1024 scan sequencer.
// Holds the FSM state type, scan mode encodings and default widths.
package mux_scan_pkg;

    localparam int SEL_W_DEF = 10;
    localparam int CNT_W_DEF = SEL_W_DEF + 1;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_FIND  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_idx.sv
// Modular index register plus remaining-sample down-counter.
// Ports: clk, rst (sync, active-high), load/step controls,
//        first_idx/last_idx window bounds, idx (current select),
//        last (no samples remain after the current one).
module mux_scan_idx #(
    parameter int SEL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [SEL_W-1:0] first_idx,
    input  logic [SEL_W-1:0] last_idx,
    output logic [SEL_W-1:0] idx,
    output logic             last
);

    logic [SEL_W-1:0] remaining;

    // Both idx and remaining wrap naturally at 2**SEL_W, which gives the
    // first > last wrap-around window and the full 1024-entry window.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            remaining <= '0;
        end else if (load) begin
            idx       <= first_idx;
            remaining <= last_idx - first_idx;
        end else if (step) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer driving the mux1024 select and sampling its output.
// Ports: clk, rst (sync, active-high), start/abort, first_idx/last_idx/mode
//        (latched on start), s (select), o_in (mux output), busy, done,
//        count (COUNT mode result), found/found_idx (FIND mode result).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SEL_W-1:0] first_idx,
    input  logic [SEL_W-1:0] last_idx,
    input  logic             mode,
    output logic [SEL_W-1:0] s,
    input  logic             o_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             found,
    output logic [SEL_W-1:0] found_idx
);

    scan_state_t state;
    scan_state_t state_nxt;

    logic mode_q;
    logic load;
    logic step;
    logic sample;
    logic idx_last;

    mux_scan_idx #(
        .SEL_W(SEL_W)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .first_idx(first_idx),
        .last_idx (last_idx),
        .idx      (s),
        .last     (idx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority over the final sample, so an aborted scan
    // never produces a done pulse and never records the aborted sample.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        sample    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    sample = 1'b1;
                    if (idx_last || (mode_q == MODE_FIND && o_in)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_COUNT;
            count     <= '0;
            found     <= 1'b0;
            found_idx <= '0;
        end else if (load) begin
            mode_q    <= mode;
            count     <= '0;
            found     <= 1'b0;
            found_idx <= '0;
        end else if (sample) begin
            if (mode_q == MODE_COUNT) begin
                count <= count + CNT_W'(o_in);
            end else if (o_in && !found) begin
                found     <= 1'b1;
                found_idx <= s;
            end
        end
    end

    assign busy = (state == ST_SCAN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural 1024:1 mux.
// Ones at mux inputs 0, 10, 123, 512 and 1023.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    localparam int SW = 10;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [SW-1:0] first_idx;
    logic [SW-1:0] last_idx;
    logic          mode;
    logic [SW-1:0] s;
    logic          o_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          found;
    logic [SW-1:0] found_idx;

    logic [1023:0] mux_in;

    always #5 clk = ~clk;

    assign o_in = mux_in[s];

    mux_scan_ctrl #(
        .SEL_W(SW),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .first_idx(first_idx),
        .last_idx (last_idx),
        .mode     (mode),
        .s        (s),
        .o_in     (o_in),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .found    (found),
        .found_idx(found_idx)
    );

    typedef struct {
        string name;
        int    cnt;
        int    fnd;
        int    fidx;
        int    slast;
        int    nbusy;
    } exp_t;

    exp_t sb[$];

    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   busy_cnt = 0;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the oldest expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt = busy_q ? busy_cnt + 1 : 1;
        busy_q = busy;
        if (done) begin
            if (done_q) begin
                chk("done_width", 2, 1);
            end else if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_count"}, int'(count), e.cnt);
                chk({e.name, "_found"}, int'(found), e.fnd);
                chk({e.name, "_found_idx"}, int'(found_idx), e.fidx);
                chk({e.name, "_s"}, int'(s), e.slast);
                chk({e.name, "_busy_cycles"}, busy_cnt, e.nbusy);
                chk({e.name, "_busy_at_done"}, int'(busy), 0);
            end
            done_seen++;
        end
        done_q = done;
    end

    task automatic push(input string n, input int c, input int f,
                        input int fi, input int sl, input int nb);
        exp_t e;
        e.name  = n;
        e.cnt   = c;
        e.fnd   = f;
        e.fidx  = fi;
        e.slast = sl;
        e.nbusy = nb;
        sb.push_back(e);
    endtask

    // Returns just after the edge that accepts start; the window inputs
    // are then scrambled to prove they are latched.
    task automatic issue(input logic m, input int f, input int l);
        @(posedge clk);
        #1;
        mode      = m;
        first_idx = SW'(f);
        last_idx  = SW'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode      = ~m;
        first_idx = SW'($urandom);
        last_idx  = SW'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n0 = done_seen;
        for (int i = 0; i < 3000 && done_seen == n0; i++) begin
            @(posedge clk);
        end
        if (done_seen == n0) chk({name, "_timeout"}, 0, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        @(negedge clk);
        chk({name, "_s"}, int'(s), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_count"}, int'(count), 0);
        chk({name, "_found"}, int'(found), 0);
        chk({name, "_found_idx"}, int'(found_idx), 0);
    endtask

    initial begin
        mux_in       = '0;
        mux_in[0]    = 1'b1;
        mux_in[10]   = 1'b1;
        mux_in[123]  = 1'b1;
        mux_in[512]  = 1'b1;
        mux_in[1023] = 1'b1;
        rst       = 1'b1;
        start     = 1'b1;
        abort     = 1'b1;
        first_idx = 10'd5;
        last_idx  = 10'd9;
        mode      = MODE_COUNT;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Full range count; a second start mid-scan must be ignored.
        push("full_count", 5, 0, 0, 1023, 1024);
        issue(MODE_COUNT, 0, 1023);
        repeat (100) @(posedge clk);
        #1;
        mode      = MODE_FIND;
        first_idx = 10'd5;
        last_idx  = 10'd6;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", int'(busy), 1);
        wait_done("full_count");

        push("find_mid", 0, 1, 123, 123, 113);
        issue(MODE_FIND, 11, 600);
        wait_done("find_mid");

        push("wrap_count", 3, 0, 0, 20, 45);
        issue(MODE_COUNT, 1000, 20);
        wait_done("wrap_count");

        push("wrap_find", 0, 1, 1023, 1023, 24);
        issue(MODE_FIND, 1000, 20);
        wait_done("wrap_find");

        push("find_none", 0, 0, 0, 511, 388);
        issue(MODE_FIND, 124, 511);
        wait_done("find_none");

        push("single_count", 1, 0, 0, 512, 1);
        issue(MODE_COUNT, 512, 512);
        wait_done("single_count");

        push("single_find0", 0, 1, 0, 0, 1);
        issue(MODE_FIND, 0, 0);
        wait_done("single_find0");

        // Abort in the 50th SCAN cycle: samples 0..48 kept, no done.
        issue(MODE_COUNT, 0, 1023);
        repeat (49) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_count", int'(count), 2);
        chk("abort_s", int'(s), 49);
        repeat (5) @(posedge clk);

        // Abort coinciding with the last sample wins.
        issue(MODE_COUNT, 512, 513);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_last_busy", int'(busy), 0);
        chk("abort_last_count", int'(count), 1);
        repeat (5) @(posedge clk);

        push("after_abort", 1, 0, 0, 10, 3);
        issue(MODE_COUNT, 8, 10);
        wait_done("after_abort");

        // Reset mid-scan clears everything.
        issue(MODE_FIND, 124, 511);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("mid_rst");
        repeat (5) @(posedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that drives the 10-bit select of the 1024:1 mux (mux1024) and samples its 1-bit output.
- Sweeps the select over a programmable index window, one index per clock.
- Either counts the asserted inputs in the window or finds the first asserted input.
- Sits between a host/CSR port (start/done handshake) and the combinational mux datapath.

Parameters:
SEL_W, 10, select width; mux input count is 2**SEL_W
CNT_W, 11, result count width; must equal SEL_W+1 so a full-range count of 1024 fits

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request a scan; accepted only in IDLE
abort  in  1  cancel an in-progress scan
first_idx  in  SEL_W  first index of window, sampled when start is accepted
last_idx  in  SEL_W  last index of window, sampled when start is accepted
mode  in  1  0 = COUNT all ones in window; 1 = FIND first one; sampled when start is accepted
s  out  SEL_W  mux select, registered
o_in  in  1  mux output o, combinationally dependent on s
busy  out  1  high while scanning
done  out  1  one-cycle pulse when results are valid
count  out  CNT_W  number of sampled ones (COUNT mode)
found  out  1  FIND mode: a one was seen
found_idx  out  SEL_W  FIND mode: index of first one seen

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. s=0, busy=0, done=0, count=0, found=0, found_idx=0. Reset overrides start and abort in the same cycle. Reset mid-scan discards all partial results.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge -> SCAN.
  - Latch first_idx, last_idx, mode. s<=first_idx, busy<=1.
  - Clear count, found, found_idx.
  - remaining <= (last_idx - first_idx) mod 2**SEL_W.
- SCAN, every edge:
  - o_in is sampled for the current s; the mux is combinational, so sampling latency is 0.
  - COUNT mode: count += o_in.
  - FIND mode: if o_in=1 and found=0, then found<=1 and found_idx<=s.
  - If remaining=0, or (FIND mode and o_in=1): go to DONE, busy<=0.
  - Otherwise: s <= s+1 mod 2**SEL_W, remaining -= 1.
- DONE: done=1 for exactly this cycle, then IDLE.
  - s holds the last sampled index.
  - Results hold until the next accepted start.
- Window and wrap:
  - first_idx > last_idx wraps: first..1023, then 0..last.
  - first_idx = last_idx samples exactly one index.
  - first=0, last=1023 samples all 1024 inputs, so count can reach 1024.
- Latency: N samples, with start accepted at edge E0, gives busy high for N cycles and done high in cycle N+1 after E0. FIND mode terminates early at the first one.
- abort=1 in SCAN: -> IDLE next edge, busy<=0, done stays 0, partial results keep their current values. abort in IDLE or DONE has no effect.
- start while busy or in DONE: ignored, not queued.
- Simultaneous abort and last sample: abort wins; no done pulse.
- Inputs o_in, first_idx, last_idx and mode changing mid-scan: only o_in is observed; the other three are latched at start.

Decomposition:
- Package mux_scan_pkg:
  - state typedef (IDLE/SCAN/DONE)
  - mode constants MODE_COUNT=0, MODE_FIND=1
  - SEL_W/CNT_W defaults
- One natural sub-module, mux_scan_idx: modular index register plus remaining-count down-counter. It provides load, step and a last flag.
- FSM and accumulators stay in mux_scan_ctrl.

Test Plan:
- Bench wiring: instantiate mux1024 with i[0], i[10], i[123], i[512] and i[1023] set to 1, all other inputs 0.
- Full-range count: COUNT, first=0, last=1023 -> busy 1024 cycles, done pulse in cycle 1025, count=5.
- Find from middle: FIND, first=11, last=600 -> found=1, found_idx=123, busy 113 cycles (index 11..123), count=0.
- Wrap-around: COUNT, first=1000, last=20 -> 45 samples, count=3 (indices 1023, 0, 10). FIND with the same window -> found_idx=1023.
- Empty and single windows:
  - FIND, first=124, last=511 -> found=0, done after 388 samples.
  - COUNT, first=last=512 -> 1 sample, count=1.
- Abort and reset:
  - abort at 50th SCAN cycle -> no done pulse, busy=0 next cycle, return to IDLE.
  - A start issued while busy -> ignored.
  - rst mid-scan -> all outputs 0 the following cycle.
